mem_copy_engine: RTL

- Bus initiator that drives the byte-addressed, 16-bit-word data memory port (address, write data, write strobe, read strobe; combinational read data) to copy a block of words from a source to a destination address.
- Sits beside the CPU datapath and shares the memory port through a request/grant pair. The CPU starts it with Start and watches Busy/Done/Error.
- Words are big-endian: byte at addr = bits [15:8], byte at addr+1 = bits [7:0]. The engine reads and writes whole words only.

---
 rtl/mem_copy_engine.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-by-word block copy initiator on the shared data memory port.
// Ports: i_Clock/i_Reset (sync, active-high); i_Start + i_SrcAddr/i_DstAddr/i_WordCount
//   launch a copy; o_Busy/o_Done/o_Error report status; o_BusReq/i_BusGnt arbitrate
//   the port; o_Adresa/o_WriteData/o_MemWrite/o_MemRead/i_ReadData form the memory port.
module mem_copy_engine #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_BYTES = 128,
    parameter int CNT_W     = 7
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Start,
    input  logic [ADDR_W-1:0] i_SrcAddr,
    input  logic [ADDR_W-1:0] i_DstAddr,
    input  logic [CNT_W-1:0]  i_WordCount,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Error,
    output logic              o_BusReq,
    input  logic              i_BusGnt,
    output logic [ADDR_W-1:0] o_Adresa,
    output logic [DATA_W-1:0] o_WriteData,
    output logic              o_MemWrite,
    output logic              o_MemRead,
    input  logic [DATA_W-1:0] i_ReadData
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    // Two extra bits so start + 2*count can never wrap.
    localparam int EXT_W = ADDR_W + 2;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_buf;
    logic              r_err;

    logic [EXT_W-1:0]  w_span;
    logic [EXT_W-1:0]  w_src_end;
    logic [EXT_W-1:0]  w_dst_end;
    logic              w_oob;
    logic              w_zero;
    logic              w_take;
    logic              w_reject;
    logic              w_accept;
    logic              w_rd;
    logic              w_wr;

    assign w_span    = EXT_W'({i_WordCount, 1'b0});
    assign w_src_end = EXT_W'(i_SrcAddr) + w_span;
    assign w_dst_end = EXT_W'(i_DstAddr) + w_span;
    assign w_oob     = (w_src_end > EXT_W'(MEM_BYTES)) ||
                       (w_dst_end > EXT_W'(MEM_BYTES));
    assign w_zero    = (i_WordCount == '0);

    // A zero-length request completes at once and skips the bounds check.
    assign w_take    = (r_state == S_IDLE) && i_Start;
    assign w_reject  = w_take && !w_zero && w_oob;
    assign w_accept  = w_take && !w_zero && !w_oob;

    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_Start) begin
                    if (w_zero) begin
                        w_next = S_DONE;
                    end else if (!w_oob) begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: begin
                if (i_BusGnt) begin
                    w_rd   = 1'b1;
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_BusGnt) begin
                    w_wr   = 1'b1;
                    w_next = (r_cnt == CNT_W'(1)) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Everything is forced quiet while reset is asserted, even mid-copy.
    always_comb begin
        o_Busy      = 1'b0;
        o_BusReq    = 1'b0;
        o_Done      = 1'b0;
        o_Error     = 1'b0;
        o_MemRead   = 1'b0;
        o_MemWrite  = 1'b0;
        o_Adresa    = '0;
        o_WriteData = '0;
        if (!i_Reset) begin
            o_Busy     = (r_state == S_READ) || (r_state == S_WRITE);
            o_BusReq   = o_Busy;
            o_Done     = (r_state == S_DONE);
            o_Error    = r_err;
            o_MemRead  = w_rd;
            o_MemWrite = w_wr;
            if (w_rd) begin
                o_Adresa = r_src;
            end else if (w_wr) begin
                o_Adresa    = r_dst;
                o_WriteData = r_buf;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_reject;
            if (w_accept) begin
                r_src <= i_SrcAddr;
                r_dst <= i_DstAddr;
                r_cnt <= i_WordCount;
            end
            if (w_rd) begin
                r_buf <= i_ReadData;
            end
            if (w_wr) begin
                r_src <= r_src + ADDR_W'(2);
                r_dst <= r_dst + ADDR_W'(2);
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule
